// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: shared header for the load/store unit.
//   BUS_WIDTH    data/address width
//   lsu_state_e  access sequencer states
//   F3_*         funct3 access size/sign encodings
//   is_aligned   natural-alignment test for an access size
//   byte_en      lane enables for an access size and byte offset
package load_store_unit_pkg;
    localparam int BUS_WIDTH = 32;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} lsu_state_e;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    // sz is funct3[1:0]: 00 byte, 01 half, otherwise word
    function automatic logic is_aligned(logic [1:0] sz, logic [1:0] off);
        return sz[1] ? off == 2'b00 : sz[0] ? !off[0] : 1'b1;
    endfunction
    function automatic logic [3:0] byte_en(logic [1:0] sz, logic [1:0] off);
        return sz[1] ? 4'b1111 : sz[0] ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
    endfunction
endpackage

// File: rtl/load_store_unit_load_extend.sv
// load_extend: picks the addressed byte/half out of a read word and extends it.
//   word_i   raw word returned by memory
//   funct3_i access size/sign (LB/LH/LW/LBU/LHU)
//   off_i    byte offset of the access within the word
//   data_o   sign/zero-extended load result
module load_extend #(
    parameter int BUS_WIDTH = load_store_unit_pkg::BUS_WIDTH
) (
    input  logic [BUS_WIDTH-1:0] word_i,
    input  logic [2:0]           funct3_i,
    input  logic [1:0]           off_i,
    output logic [BUS_WIDTH-1:0] data_o
);
    import load_store_unit_pkg::*;
    logic [BUS_WIDTH-1:0] sh;
    // Aligned accesses only reach here, so shifting by the offset leaves the
    // wanted byte/half in the low lanes (a word always has offset 0).
    assign sh = word_i >> {off_i, 3'b000};
    assign data_o = funct3_i == F3_B  ? {{(BUS_WIDTH-8){sh[7]}}, sh[7:0]} :
                    funct3_i == F3_H  ? {{(BUS_WIDTH-16){sh[15]}}, sh[15:0]} :
                    funct3_i == F3_BU ? {{(BUS_WIDTH-8){1'b0}}, sh[7:0]} :
                    funct3_i == F3_HU ? {{(BUS_WIDTH-16){1'b0}}, sh[15:0]} : sh;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequences datapath loads/stores onto a req/gnt/rvalid memory port.
//   clk, rst              clock, asynchronous active-low reset
//   rd_en, wr_en          load / store request (both high = store)
//   funct3, addr, wdata   access size/sign, byte address, store data
//   rdata                 extended load result, valid for one cycle in DONE
//   stall, misalign       pipeline hold, one-cycle misaligned-access flag
//   mem_req..mem_wdata    registered word-address memory request
//   mem_gnt, mem_rvalid, mem_rdata  memory handshake and read data
module load_store_unit #(
    parameter int BUS_WIDTH = load_store_unit_pkg::BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [2:0]           funct3,
    input  logic [BUS_WIDTH-1:0] addr,
    input  logic [BUS_WIDTH-1:0] wdata,
    output logic [BUS_WIDTH-1:0] rdata,
    output logic                 stall,
    output logic                 misalign,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [BUS_WIDTH-3:0] mem_addr,
    output logic [3:0]           mem_be,
    output logic [BUS_WIDTH-1:0] mem_wdata,
    input  logic                 mem_gnt,
    input  logic                 mem_rvalid,
    input  logic [BUS_WIDTH-1:0] mem_rdata
);
    import load_store_unit_pkg::*;
    lsu_state_e           state_q, state_d;
    logic [BUS_WIDTH-3:0] addr_q, addr_d;
    logic [3:0]           be_q, be_d;
    logic [BUS_WIDTH-1:0] wdata_q, wdata_d, cap_q, cap_d, ext;
    logic                 we_q, we_d;
    logic [2:0]           f3_q, f3_d;
    logic [1:0]           off_q, off_d;
    logic                 acc, aligned;
    assign acc     = rd_en | wr_en;
    assign aligned = is_aligned(funct3[1:0], addr[1:0]);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cap_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            off_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cap_q   <= cap_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
        end
    end
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cap_d   = cap_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        case (state_q)
            IDLE: if (acc && aligned) begin
                state_d = REQ;
                addr_d  = addr[BUS_WIDTH-1:2];
                be_d    = byte_en(funct3[1:0], addr[1:0]);
                // Replicate narrow store data so every enabled lane carries it
                wdata_d = funct3[1] ? wdata : funct3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
                we_d    = wr_en;
                f3_d    = funct3;
                off_d   = addr[1:0];
            end
            REQ: if (mem_gnt) begin
                state_d = we_q ? DONE : mem_rvalid ? DONE : WAIT_R;
                cap_d   = !we_q && mem_rvalid ? mem_rdata : cap_q;
            end
            WAIT_R: if (mem_rvalid) begin
                state_d = DONE;
                cap_d   = mem_rdata;
            end
            default: state_d = IDLE;
        endcase
    end
    load_extend #(.BUS_WIDTH(BUS_WIDTH)) u_ext (
        .word_i  (cap_q),
        .funct3_i(f3_q),
        .off_i   (off_q),
        .data_o  (ext)
    );
    assign stall     = state_q == REQ || state_q == WAIT_R || (state_q == IDLE && acc && aligned);
    assign misalign  = state_q == IDLE && acc && !aligned;
    assign mem_req   = state_q == REQ;
    assign mem_we    = mem_req & we_q;
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign rdata     = state_q == DONE && !we_q ? ext : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random transactions against an arithmetic reference model.
module tb_load_store_unit;
    logic        clk = 1'b0, rst = 1'b0;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] addr = '0, wdata = '0, rdata, mem_wdata, mem_rdata = '0;
    logic        stall, misalign, mem_req, mem_we, mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    int          errors = 0, checks = 0;

    load_store_unit dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .funct3(funct3),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .misalign(misalign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_be(input int n, input int off);
        int v;
        v = ((1 << n) - 1) << off;
        return v;
    endfunction

    function automatic logic [31:0] m_wd(input int n, input logic [31:0] wd);
        logic [31:0] b, h;
        b = wd & 32'hFF;
        h = wd & 32'hFFFF;
        return n == 1 ? b * 32'h01010101 : n == 2 ? h * 32'h00010001 : wd;
    endfunction

    function automatic logic [31:0] m_rd(input logic [2:0] f3, input int off, input logic [31:0] word);
        int n;
        logic [31:0] mask, v;
        n = nbytes(f3);
        mask = n == 4 ? 32'hFFFFFFFF : (32'd1 << (8 * n)) - 1;
        v = (word >> (8 * off)) & mask;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // Starts just after a rising edge with the unit idle; ends the same way.
    task automatic txn(input bit st, input bit both, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] word, input int gd, input int rd,
                       input bit same);
        int n, off;
        bit al;
        n = nbytes(f3);
        off = a % 4;
        al = (a % n) == 0;
        rd_en = !st || both;
        wr_en = st;
        funct3 = f3;
        addr = a;
        wdata = wd;
        @(negedge clk);
        chk("stall_accept", stall, al);
        chk("misalign", misalign, !al);
        chk("req_idle", mem_req, 0);
        if (!al) begin
            chk("rdata_misalign", rdata, 0);
            @(posedge clk); #1;
            rd_en = 0;
            wr_en = 0;
            @(negedge clk);
            chk("misalign_once", misalign, 0);
            chk("req_after_misalign", mem_req, 0);
            chk("stall_after_misalign", stall, 0);
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        for (int i = 0; i <= gd; i++) begin
            if (i == gd) begin
                mem_gnt = 1;
                if (same) begin
                    mem_rvalid = 1;
                    mem_rdata = word;
                end
            end
            @(negedge clk);
            chk("req_high", mem_req, 1);
            chk("stall_req", stall, 1);
            chk("mem_we", mem_we, st);
            chk("mem_addr", mem_addr, a >> 2);
            chk("mem_be", mem_be, m_be(n, off));
            if (st) chk("mem_wdata", mem_wdata, m_wd(n, wd));
            @(posedge clk); #1;
            mem_gnt = 0;
            mem_rvalid = 0;
            mem_rdata = $urandom;
        end
        if (!st && !same) begin
            for (int i = 0; i <= rd; i++) begin
                if (i == rd) begin
                    mem_rvalid = 1;
                    mem_rdata = word;
                end
                @(negedge clk);
                chk("req_wait", mem_req, 0);
                chk("stall_wait", stall, 1);
                @(posedge clk); #1;
                mem_rvalid = 0;
                mem_rdata = $urandom;
            end
        end
        rd_en = 0;
        wr_en = 0;
        addr = $urandom;
        wdata = $urandom;
        @(negedge clk);
        chk("stall_done", stall, 0);
        chk("req_done", mem_req, 0);
        if (!st) chk("rdata_done", rdata, m_rd(f3, off, word));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rdata_idle", rdata, 0);
        chk("stall_idle", stall, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        @(negedge clk);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_stall", stall, 0);
        chk("rst_misalign", misalign, 0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        txn(0, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 1, 0);
        txn(1, 0, 3'b000, 32'h103, 32'h000000A5, 0, 0, 0, 0);
        txn(0, 0, 3'b000, 32'h102, 0, 32'h12F00000, 1, 0, 0);
        txn(0, 0, 3'b100, 32'h102, 0, 32'h12F00000, 0, 2, 0);
        txn(0, 0, 3'b001, 32'h101, 0, 0, 0, 0, 0);
        txn(0, 0, 3'b010, 32'h104, 0, 32'h00000001, 0, 0, 1);
        txn(1, 1, 3'b001, 32'h10E, 32'h1234BEEF, 0, 1, 0, 0);
        // Reset while waiting for read data: the pending response must be dropped
        rd_en = 1;
        funct3 = 3'b010;
        addr = 32'h200;
        @(posedge clk); #1;
        mem_gnt = 1;
        @(posedge clk); #1;
        mem_gnt = 0;
        @(negedge clk);
        chk("wait_before_rst", stall, 1);
        rd_en = 0;
        rst = 0;
        #1;
        chk("rst_async_req", mem_req, 0);
        chk("rst_async_stall", stall, 0);
        chk("rst_async_be", mem_be, 0);
        @(posedge clk); #1;
        rst = 1;
        mem_rvalid = 1;
        mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("late_rvalid_rdata", rdata, 0);
        chk("late_rvalid_stall", stall, 0);
        @(posedge clk); #1;
        mem_rvalid = 0;
        @(negedge clk);
        chk("late_rvalid_done", rdata, 0);
        chk("late_rvalid_req", mem_req, 0);
        @(posedge clk); #1;
        txn(0, 0, 3'b010, 32'h300, 0, 32'hCAFEF00D, 1, 1, 0);
        for (int k = 0; k < 60; k++) begin
            bit st, both, same;
            logic [2:0] f3;
            logic [31:0] a;
            int sel;
            st = $urandom_range(0, 1);
            sel = st ? $urandom_range(0, 2) : $urandom_range(0, 4);
            f3 = sel == 3 ? 3'b100 : sel == 4 ? 3'b101 : 3'(sel);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'(nbytes(f3) - 1);
            both = st && $urandom_range(0, 1);
            same = !st && $urandom_range(0, 3) == 0;
            txn(st, both, f3, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), same);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
